fir_result_collector: RTL
=========================

Name: fir_result_collector

Overview:
- AXI-Stream sink that sits directly downstream of the FIR output stream (sm_tvalid/sm_tdata/sm_tlast/sm_tready).
- Captures every output sample into a bram11-style result RAM and keeps a running sample count, a checksum, and signed min/max.
- Checks that the stream length agrees with the programmed data length and tlast, and raises done and error flags for the host or firmware.

Parameters:
pADDR_WIDTH, 12, byte-address width of the result RAM port
pDATA_WIDTH, 32, sample width (signed)
DEPTH, 1024, result RAM depth in words; write index wraps modulo DEPTH

Ports:
axis_clk  in  1  single clock
axis_rst  in  1  synchronous, active-high reset
cfg_len  in  32  expected sample count; sampled on arm
arm  in  1  one-cycle pulse that starts a capture
stall  in  1  forces s_tready low (backpressure injection)
s_tvalid  in  1  stream valid (from FIR sm_tvalid)
s_tdata  in  pDATA_WIDTH  signed stream sample
s_tlast  in  1  stream last
s_tready  out  1  stream ready
ram_WE  out  4  byte write enables
ram_EN  out  1  RAM enable
ram_Di  out  pDATA_WIDTH  RAM write data
ram_A  out  pADDR_WIDTH  RAM byte address (4*index)
busy  out  1  capture in progress
done  out  1  capture finished (sticky until next arm)
sample_cnt  out  32  accepted samples
checksum  out  32  sum of accepted samples, modulo 2^32
min_val  out  pDATA_WIDTH  signed minimum of accepted samples
max_val  out  pDATA_WIDTH  signed maximum of accepted samples
err_early_last  out  1  tlast accepted before cfg_len samples
err_missing_last  out  1  cfg_len-th sample accepted without tlast
wrapped  out  1  more than DEPTH samples accepted (buffer overwritten)

Behaviour:
- Reset (synchronous, axis_rst=1 at the edge) sets every output and register to 0 and the state to IDLE. It overrides everything, including a capture in progress; no partial write is issued afterwards.
- FSM states are IDLE, RUN, DONE.
- IDLE: s_tready=0. When arm=1, latch cfg_len, clear cnt/checksum/min/max/all error flags/wrapped/done, then go to RUN. If the latched cfg_len is 0, go directly to DONE with no flags set.
- RUN: busy=1 and s_tready = ~stall (combinational from state and stall). arm is ignored.
- Accept = s_tvalid & s_tready. On each accept edge:
  - cnt += 1
  - checksum += s_tdata (wraps)
  - min/max updated with signed compare; the first sample loads both
  - if cnt (before the increment) >= DEPTH, set wrapped
- End of capture on the accept edge where either tlast=1 or cnt+1 == cfg_len:
  - tlast and cnt+1 == cfg_len: clean end, no flags.
  - tlast and cnt+1 < cfg_len: set err_early_last.
  - cnt+1 == cfg_len and no tlast: set err_missing_last.
  - In all three cases go to DONE.
- DONE: done=1, busy=0, s_tready=0. arm behaves as in IDLE (re-capture); status outputs hold their values until that arm.
- RAM write is registered, 1-cycle latency. The cycle after an accept: ram_EN=1, ram_WE=4'hF, ram_A = 4*(index mod DEPTH), ram_Di = the accepted sample. Otherwise ram_EN=0 and ram_WE=0. The final write occurs in the first DONE cycle.
- Back-to-back accepts sustain 1 sample/cycle.
- s_tdata and s_tlast are ignored when there is no accept. Holding s_tvalid high while s_tready=0 changes nothing.

Decomposition:
- Shared package holds the state encoding (IDLE/RUN/DONE), pDATA_WIDTH/pADDR_WIDTH defaults, and the WE_ALL=4'hF constant.
- One sub-module: fir_result_stats, covering count, checksum, and signed min/max with a clear input.
- The FSM and RAM write register stay in the top module.

Test Plan:
- Reset, arm with cfg_len=3, send 5, -3, 7 with tlast on the 3rd sample -> done=1, cnt=3, checksum=9, min=-3, max=7, no errors; RAM writes at A=0,4,8 with Di 5, -3, 7, each one cycle after its accept.
- cfg_len=4, send 3 samples with tlast on the 3rd -> err_early_last=1, done=1, cnt=3.
- cfg_len=2, send 2 samples with no tlast -> err_missing_last=1, done=1, s_tready=0 afterwards, cnt=2.
- cfg_len=600, stall toggling every other cycle, s_tvalid held high -> exactly 600 accepts, the write sequence is unbroken, and checksum equals the software sum.
- DEPTH=8, cfg_len=10 -> wrapped=1, 9th sample written at A=0, 10th at A=4.
- Assert axis_rst mid-RUN after 2 samples -> all outputs 0 on the next edge, s_tready=0, no further RAM write; a new arm with cfg_len=1 and one tlast sample -> clean done.

Source files
------------

// File: rtl/fir_result_collector_pkg.sv
// Shared definitions for the FIR result collector: state encoding, width defaults, write-enable constant.
package fir_result_collector_pkg;

  localparam int P_ADDR_WIDTH_DEF = 12;
  localparam int P_DATA_WIDTH_DEF = 32;

  localparam logic [3:0] WE_ALL = 4'hF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/fir_result_stats.sv
// Running count, wrapping checksum and signed min/max of accepted samples; updates on the accept edge.
// Clear wins over accept so a new capture always starts from an empty set.
module fir_result_stats
  import fir_result_collector_pkg::*;
#(
  parameter int pDATA_WIDTH = P_DATA_WIDTH_DEF
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          clear,
  input  logic                          accept,
  input  logic signed [pDATA_WIDTH-1:0] data,
  output logic        [31:0]            cnt,
  output logic        [31:0]            checksum,
  output logic signed [pDATA_WIDTH-1:0] min_val,
  output logic signed [pDATA_WIDTH-1:0] max_val
);

  logic first;
  assign first = (cnt == 32'd0);

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cnt      <= '0;
      checksum <= '0;
      min_val  <= '0;
      max_val  <= '0;
    end else if (accept) begin
      cnt      <= cnt + 32'd1;
      checksum <= checksum + 32'(data);
      // The first sample seeds both extremes regardless of the cleared zeros.
      if (first || (data < min_val)) min_val <= data;
      if (first || (data > max_val)) max_val <= data;
    end
  end

endmodule

// File: rtl/fir_result_collector.sv
// AXI-Stream sink capturing FIR output into a result RAM; RAM write lands 1 cycle after accept.
// s_tready is high only while capturing and stall is low; 1 sample/cycle sustained.
module fir_result_collector
  import fir_result_collector_pkg::*;
#(
  parameter int pADDR_WIDTH = P_ADDR_WIDTH_DEF,
  parameter int pDATA_WIDTH = P_DATA_WIDTH_DEF,
  parameter int DEPTH       = 1024
) (
  input  logic                   axis_clk,
  input  logic                   axis_rst,
  input  logic [31:0]            cfg_len,
  input  logic                   arm,
  input  logic                   stall,
  input  logic                   s_tvalid,
  input  logic [pDATA_WIDTH-1:0] s_tdata,
  input  logic                   s_tlast,
  output logic                   s_tready,
  output logic [3:0]             ram_WE,
  output logic                   ram_EN,
  output logic [pDATA_WIDTH-1:0] ram_Di,
  output logic [pADDR_WIDTH-1:0] ram_A,
  output logic                   busy,
  output logic                   done,
  output logic [31:0]            sample_cnt,
  output logic [31:0]            checksum,
  output logic [pDATA_WIDTH-1:0] min_val,
  output logic [pDATA_WIDTH-1:0] max_val,
  output logic                   err_early_last,
  output logic                   err_missing_last,
  output logic                   wrapped
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  state_t           state, state_nxt;
  logic [31:0]      len_q;
  logic [IDX_W-1:0] wr_idx;
  logic             accept;
  logic             arm_take;
  logic             end_hit;
  logic [31:0]      cnt_nxt;

  assign accept   = s_tvalid && s_tready;
  assign arm_take = arm && (state != RUN);
  assign cnt_nxt  = sample_cnt + 32'd1;
  assign end_hit  = accept && (s_tlast || (cnt_nxt == len_q));

  always_comb begin
    state_nxt = state;
    s_tready  = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (arm) state_nxt = (cfg_len == 32'd0) ? DONE : RUN;
      end
      RUN: begin
        busy     = 1'b1;
        s_tready = !stall;
        if (end_hit) state_nxt = DONE;
      end
      DONE: begin
        done = 1'b1;
        if (arm) state_nxt = (cfg_len == 32'd0) ? DONE : RUN;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge axis_clk) begin
    if (axis_rst) state <= IDLE;
    else          state <= state_nxt;
  end

  // Length checks use the post-increment count so the cfg_len-th sample is the one compared.
  always_ff @(posedge axis_clk) begin
    if (axis_rst) begin
      len_q            <= '0;
      wr_idx           <= '0;
      ram_EN           <= 1'b0;
      ram_WE           <= '0;
      ram_A            <= '0;
      ram_Di           <= '0;
      err_early_last   <= 1'b0;
      err_missing_last <= 1'b0;
      wrapped          <= 1'b0;
    end else begin
      ram_EN <= accept;
      ram_WE <= accept ? WE_ALL : 4'h0;
      if (accept) begin
        ram_A  <= pADDR_WIDTH'({wr_idx, 2'b00});
        ram_Di <= s_tdata;
        wr_idx <= (wr_idx == IDX_W'(DEPTH - 1)) ? '0 : wr_idx + IDX_W'(1);
        if (sample_cnt >= 32'(DEPTH))            wrapped          <= 1'b1;
        if (s_tlast && (cnt_nxt < len_q))        err_early_last   <= 1'b1;
        if (!s_tlast && (cnt_nxt == len_q))      err_missing_last <= 1'b1;
      end
      if (arm_take) begin
        len_q            <= cfg_len;
        wr_idx           <= '0;
        err_early_last   <= 1'b0;
        err_missing_last <= 1'b0;
        wrapped          <= 1'b0;
      end
    end
  end

  fir_result_stats #(
    .pDATA_WIDTH(pDATA_WIDTH)
  ) u_stats (
    .clk      (axis_clk),
    .rst      (axis_rst),
    .clear    (arm_take),
    .accept   (accept),
    .data     (s_tdata),
    .cnt      (sample_cnt),
    .checksum (checksum),
    .min_val  (min_val),
    .max_val  (max_val)
  );

endmodule
